// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
//  Module   : mc_control
//  Purpose  : Main control unit of a multi-cycle MIPS-style datapath. A Moore
//             FSM that walks each instruction through FETCH / DECODE and a
//             per-class execution path. It produces the datapath strobes.
//  Revision : 1.0  initial release
//
//  Build option:
//    MC_CTRL_ADDI_EN  when defined, opcode 0x08 (addi) runs through
//                     ADDI_EX -> ADDI_WB. When undefined, addi is treated
//                     as an illegal instruction.
//
//  Ports:
//    clk             sole clock, rising edge
//    rst             synchronous active-high reset
//    opcode_i[5:0]   IR[31:26], valid from DECODE onward
//    funct_i[5:0]    IR[5:0]
//    zero_i          ALU equality flag (a == b)
//    mem_ready_i     memory access completes this cycle
//    pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o,
//    ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o
//                    1-bit datapath controls
//    alu_src_b_o[1:0], pc_source_o[1:0]  mux selects
//    alu_op_o[2:0]   010 add, 011 sub, 100 or, 101 and, 111 slt
//    pc_en_o         pc_write | (pc_write_cond & zero)
//    illegal_o       one-cycle pulse for an undecodable instruction
//    state_o[3:0]    current state, for debug
// ============================================================================
module mc_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       mem_to_reg_o,
  output logic       reg_dst_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] pc_source_o,
  output logic [2:0] alu_op_o,
  output logic       pc_en_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    ST_RESET     = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_READ  = 4'd4,
    ST_MEM_WB    = 4'd5,
    ST_MEM_WRITE = 4'd6,
    ST_R_EXEC    = 4'd7,
    ST_R_WB      = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JUMP      = 4'd10,
    ST_ADDI_EX   = 4'd11,
    ST_ADDI_WB   = 4'd12,
    ST_ILLEGAL   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state_q;
  state_t state_d;
  logic   rst_q;
  logic   funct_ok;

  assign funct_ok = (funct_i == FN_ADD) || (funct_i == FN_SUB) ||
                    (funct_i == FN_AND) || (funct_i == FN_OR)  ||
                    (funct_i == FN_SLT);

  // The release of reset is registered, so RESET is held for one more cycle
  // after rst is first sampled low. The first FETCH therefore lands on the
  // second edge after rst falls.
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst || rst_q) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_RESET:     state_d = ST_FETCH;
      ST_FETCH:     state_d = mem_ready_i ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        state_d = ST_ILLEGAL;
        case (opcode_i)
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_RTYPE:     state_d = funct_ok ? ST_R_EXEC : ST_ILLEGAL;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
`ifdef MC_CTRL_ADDI_EN
          OP_ADDI:      state_d = ST_ADDI_EX;
`endif
          default:      state_d = ST_ILLEGAL;
        endcase
      end
      ST_MEM_ADDR:  state_d = (opcode_i == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ:  state_d = mem_ready_i ? ST_MEM_WB : ST_MEM_READ;
      ST_MEM_WB:    state_d = ST_FETCH;
      ST_MEM_WRITE: state_d = mem_ready_i ? ST_FETCH : ST_MEM_WRITE;
      ST_R_EXEC:    state_d = ST_R_WB;
      ST_R_WB:      state_d = ST_FETCH;
      ST_BRANCH:    state_d = ST_FETCH;
      ST_JUMP:      state_d = ST_FETCH;
`ifdef MC_CTRL_ADDI_EN
      ST_ADDI_EX:   state_d = ST_ADDI_WB;
      ST_ADDI_WB:   state_d = ST_FETCH;
`endif
      ST_ILLEGAL:   state_d = ST_FETCH;
      // Unused codes, and the addi states when addi is disabled, recover
      // to FETCH.
      default:      state_d = ST_FETCH;
    endcase
  end

  // Output decode. Only ir_write / pc_write in FETCH look at an input;
  // everything else is a function of the state register.
  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    iord_o          = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_dst_o       = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'b00;
    pc_source_o     = 2'b00;
    alu_op_o        = 3'b000;
    illegal_o       = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        alu_op_o    = ALU_ADD;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      ST_DECODE: begin
        alu_src_b_o = 2'b11;
        alu_op_o    = ALU_ADD;
      end
      ST_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = ALU_ADD;
      end
      ST_MEM_READ: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      ST_MEM_WRITE: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
      end
      ST_R_EXEC: begin
        alu_src_a_o = 1'b1;
        case (funct_i)
          FN_SUB:  alu_op_o = ALU_SUB;
          FN_AND:  alu_op_o = ALU_AND;
          FN_OR:   alu_op_o = ALU_OR;
          FN_SLT:  alu_op_o = ALU_SLT;
          default: alu_op_o = ALU_ADD;
        endcase
      end
      ST_R_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = ALU_SUB;
        pc_write_cond_o = 1'b1;
        pc_source_o     = 2'b01;
      end
      ST_JUMP: begin
        pc_write_o  = 1'b1;
        pc_source_o = 2'b10;
      end
`ifdef MC_CTRL_ADDI_EN
      ST_ADDI_EX: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = ALU_ADD;
      end
      ST_ADDI_WB: begin
        reg_write_o = 1'b1;
      end
`endif
      ST_ILLEGAL: begin
        illegal_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign pc_en_o = pc_write_o | (pc_write_cond_o & zero_i);
  assign state_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_control
//  Purpose  : Self-checking bench for mc_control. It runs directed scenarios
//             and then a randomized run against an instruction-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, pc_en, illegal;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;

  mc_control dut (
    .clk             (clk),
    .rst             (rst),
    .opcode_i        (opcode),
    .funct_i         (funct),
    .zero_i          (zero),
    .mem_ready_i     (mem_ready),
    .pc_write_o      (pc_write),
    .pc_write_cond_o (pc_write_cond),
    .iord_o          (iord),
    .mem_read_o      (mem_read),
    .mem_write_o     (mem_write),
    .ir_write_o      (ir_write),
    .mem_to_reg_o    (mem_to_reg),
    .reg_dst_o       (reg_dst),
    .reg_write_o     (reg_write),
    .alu_src_a_o     (alu_src_a),
    .alu_src_b_o     (alu_src_b),
    .pc_source_o     (pc_source),
    .alu_op_o        (alu_op),
    .pc_en_o         (pc_en),
    .illegal_o       (illegal),
    .state_o         (state)
  );

  always #5 clk = ~clk;

  // Observed control bundle, in a fixed order shared with exp_outs().
  logic [18:0] obs;
  assign obs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                pc_source, alu_op, pc_en, illegal};

  // Advance one clock; inputs are then driven mid-cycle, well away from edges.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reset and leave the DUT sitting in its first FETCH cycle.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
  endtask

  // ---------------- behavioural reference ----------------
  function automatic logic is_rfunct(logic [5:0] fn);
    return (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) ||
           (fn == 6'h25) || (fn == 6'h2A);
  endfunction

  function automatic logic [2:0] r_aluop(logic [5:0] fn);
    case (fn)
      6'h20:   return 3'b010;
      6'h22:   return 3'b011;
      6'h24:   return 3'b101;
      6'h25:   return 3'b100;
      6'h2A:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // Expected control bundle for a state number and the current inputs.
  function automatic logic [18:0] exp_outs(int st, logic mr, logic z, logic [5:0] fn);
    logic pcw, pcwc, io, mrd, mwr, irw, m2r, rd, rw, asa, ill;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    pcw = 0; pcwc = 0; io = 0; mrd = 0; mwr = 0; irw = 0; m2r = 0;
    rd = 0; rw = 0; asa = 0; ill = 0; asb = 2'b00; pcs = 2'b00; aop = 3'b000;
    case (st)
      1:  begin mrd = 1; asb = 2'b01; aop = 3'b010; irw = mr; pcw = mr; end
      2:  begin asb = 2'b11; aop = 3'b010; end
      3:  begin asa = 1; asb = 2'b10; aop = 3'b010; end
      4:  begin mrd = 1; io = 1; end
      5:  begin rw = 1; m2r = 1; end
      6:  begin mwr = 1; io = 1; end
      7:  begin asa = 1; aop = r_aluop(fn); end
      8:  begin rw = 1; rd = 1; end
      9:  begin asa = 1; aop = 3'b011; pcwc = 1; pcs = 2'b01; end
      10: begin pcw = 1; pcs = 2'b10; end
`ifdef MC_CTRL_ADDI_EN
      11: begin asa = 1; asb = 2'b10; aop = 3'b010; end
      12: begin rw = 1; end
`endif
      13: begin ill = 1; end
      default: begin end
    endcase
    return {pcw, pcwc, io, mrd, mwr, irw, m2r, rd, rw, asa, asb, pcs, aop,
            pcw | (pcwc & z), ill};
  endfunction

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; zero = 1'b1; opcode = 6'h23;
    tick();
    tick();
    #1;
    tests++;
    if (state !== 4'd0) begin
      fails++; $display("FAIL reset_state got=%0d exp=0", state);
    end
    tests++;
    if (obs !== 19'd0) begin
      fails++; $display("FAIL reset_outputs got=%b exp=%b", obs, 19'd0);
    end
    rst = 1'b0;
    tick();
    #1;
    tests++;
    if (state !== 4'd0 || obs !== 19'd0) begin
      fails++; $display("FAIL reset_release_edge1 state got=%0d exp=0 outs=%b", state, obs);
    end
    tick();
    #1;
    tests++;
    if (state !== 4'd1) begin
      fails++; $display("FAIL reset_first_fetch got=%0d exp=1", state);
    end
    tests++;
    if (ir_write !== 1'b1 || pc_write !== 1'b1 || pc_en !== 1'b1 ||
        mem_read !== 1'b1 || alu_src_b !== 2'b01 || alu_op !== 3'b010) begin
      fails++; $display("FAIL fetch_outputs got=%b exp=%b", obs, exp_outs(1, 1'b1, 1'b1, 6'h00));
    end
  endtask

  task automatic test_rtype();
    int exp_st[5];
    exp_st = '{1, 2, 7, 8, 1};
    do_reset();
    opcode = 6'h00; funct = 6'h2A; mem_ready = 1'b1; zero = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++;
      if (state !== 4'(exp_st[i])) begin
        fails++; $display("FAIL rtype_state step=%0d got=%0d exp=%0d", i, state, exp_st[i]);
      end
      if (i == 2) begin
        tests++;
        if (alu_op !== 3'b111 || alu_src_a !== 1'b1 || alu_src_b !== 2'b00) begin
          fails++; $display("FAIL rtype_exec alu_op got=%b exp=111 src_a=%b src_b=%b", alu_op, alu_src_a, alu_src_b);
        end
      end
      if (i == 3) begin
        tests++;
        if (reg_write !== 1'b1 || reg_dst !== 1'b1 || mem_to_reg !== 1'b0) begin
          fails++; $display("FAIL rtype_wb got rw=%b rd=%b m2r=%b exp 1 1 0", reg_write, reg_dst, mem_to_reg);
        end
      end
      tick();
    end
  endtask

  task automatic test_lw_wait();
    int held;
    held = 0;
    do_reset();
    opcode = 6'h23; funct = 6'h00; mem_ready = 1'b1;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      #1;
      if (state === 4'd4 && iord === 1'b1 && mem_read === 1'b1) held++;
      tick();
    end
    #1;
    tests++;
    if (held != 4) begin
      fails++; $display("FAIL lw_wait_cycles got=%0d exp=4", held);
    end
    tests++;
    if (state !== 4'd5 || mem_to_reg !== 1'b1 || reg_write !== 1'b1 || reg_dst !== 1'b0) begin
      fails++; $display("FAIL lw_memwb state got=%0d exp=5 m2r=%b rw=%b rd=%b", state, mem_to_reg, reg_write, reg_dst);
    end
    tick();
    #1;
    tests++;
    if (state !== 4'd1) begin
      fails++; $display("FAIL lw_return got=%0d exp=1", state);
    end
  endtask

  task automatic test_beq();
    logic z;
    for (int k = 0; k < 2; k++) begin
      z = (k == 0);
      do_reset();
      opcode = 6'h04; mem_ready = 1'b1; zero = z;
      tick();
      tick();
      #1;
      tests++;
      if (state !== 4'd9 || pc_en !== z || pc_source !== 2'b01 ||
          pc_write_cond !== 1'b1 || alu_op !== 3'b011) begin
        fails++; $display("FAIL beq_zero%0d state got=%0d exp=9 pc_en got=%b exp=%b pcs=%b", z, state, pc_en, z, pc_source);
      end
      tick();
      #1;
      tests++;
      if (state !== 4'd1) begin
        fails++; $display("FAIL beq_return got=%0d exp=1", state);
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    opcode = 6'h3F; mem_ready = 1'b1;
    tick();
    tick();
    #1;
    tests++;
    if (state !== 4'd13 || illegal !== 1'b1 || reg_write !== 1'b0 || mem_write !== 1'b0) begin
      fails++; $display("FAIL illegal_state got=%0d exp=13 illegal=%b", state, illegal);
    end
    tick();
    #1;
    tests++;
    if (state !== 4'd1 || illegal !== 1'b0) begin
      fails++; $display("FAIL illegal_return got=%0d exp=1 illegal=%b", state, illegal);
    end
    do_reset();
    opcode = 6'h08; mem_ready = 1'b1;
    tick();
    tick();
    #1;
`ifdef MC_CTRL_ADDI_EN
    tests++;
    if (state !== 4'd11 || alu_src_a !== 1'b1 || alu_src_b !== 2'b10 || alu_op !== 3'b010) begin
      fails++; $display("FAIL addi_ex state got=%0d exp=11 outs=%b", state, obs);
    end
    tick();
    #1;
    tests++;
    if (state !== 4'd12 || reg_write !== 1'b1 || reg_dst !== 1'b0 || mem_to_reg !== 1'b0) begin
      fails++; $display("FAIL addi_wb state got=%0d exp=12 outs=%b", state, obs);
    end
`else
    tests++;
    if (state !== 4'd13 || illegal !== 1'b1) begin
      fails++; $display("FAIL addi_disabled state got=%0d exp=13 illegal=%b", state, illegal);
    end
`endif
    tick();
    #1;
    tests++;
    if (state !== 4'd1) begin
      fails++; $display("FAIL addi_return got=%0d exp=1", state);
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    opcode = 6'h2B; mem_ready = 1'b1;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    #1;
    tests++;
    if (state !== 4'd6 || mem_write !== 1'b1 || iord !== 1'b1) begin
      fails++; $display("FAIL sw_wait state got=%0d exp=6 mem_write=%b", state, mem_write);
    end
    tick();
    rst = 1'b1;
    #1;
    tests++;
    if (state !== 4'd6) begin
      fails++; $display("FAIL sw_hold got=%0d exp=6", state);
    end
    tick();
    #1;
    tests++;
    if (state !== 4'd0 || mem_write !== 1'b0 || obs !== 19'd0) begin
      fails++; $display("FAIL reset_mid_write state got=%0d exp=0 mem_write=%b", state, mem_write);
    end
    rst = 1'b0;
    mem_ready = 1'b1;
    tick();
    tick();
    #1;
    tests++;
    if (state !== 4'd1) begin
      fails++; $display("FAIL reset_mid_write_recover got=%0d exp=1", state);
    end
  endtask

  task automatic test_random();
    int mst;
    int nst;
    int path[$];
    logic rst_prev;
    logic [18:0] exp;
    do_reset();
    mst = 1;
    rst_prev = 1'b0;
    path.delete();
    for (int c = 0; c < 1500; c++) begin
      if (mst == 1) begin
        case ($urandom_range(0, 7))
          0:       opcode = 6'h23;
          1:       opcode = 6'h2B;
          2, 3:    opcode = 6'h00;
          4:       opcode = 6'h04;
          5:       opcode = 6'h02;
          6:       opcode = 6'h08;
          default: opcode = 6'($urandom());
        endcase
        case ($urandom_range(0, 5))
          0:       funct = 6'h20;
          1:       funct = 6'h22;
          2:       funct = 6'h24;
          3:       funct = 6'h25;
          4:       funct = 6'h2A;
          default: funct = 6'($urandom());
        endcase
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      zero = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 79) == 0);
      #1;
      exp = exp_outs(mst, mem_ready, zero, funct);
      tests++;
      if (state !== 4'(mst)) begin
        fails++; $display("FAIL random_state cyc=%0d got=%0d exp=%0d", c, state, mst);
      end
      tests++;
      if (obs !== exp) begin
        fails++; $display("FAIL random_outs cyc=%0d state=%0d got=%b exp=%b", c, mst, obs, exp);
      end
      // Instruction-level model: DECODE selects the remaining path of the
      // instruction; memory states stall on mem_ready.
      if (rst || rst_prev) begin
        nst = 0;
        path.delete();
      end else if (mst == 0) begin
        nst = 1;
      end else if (mst == 1) begin
        nst = mem_ready ? 2 : 1;
      end else if (mst == 2) begin
        path.delete();
        if (opcode == 6'h23) path = '{3, 4, 5};
        else if (opcode == 6'h2B) path = '{3, 6};
        else if (opcode == 6'h00 && is_rfunct(funct)) path = '{7, 8};
        else if (opcode == 6'h04) path = '{9};
        else if (opcode == 6'h02) path = '{10};
`ifdef MC_CTRL_ADDI_EN
        else if (opcode == 6'h08) path = '{11, 12};
`endif
        else path = '{13};
        nst = path.pop_front();
      end else if ((mst == 4 || mst == 6) && !mem_ready) begin
        nst = mst;
      end else begin
        nst = (path.size() > 0) ? path.pop_front() : 1;
      end
      rst_prev = rst;
      mst = nst;
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_reset_mid_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port opcode, input, 6, instruction register bits [31:26]; valid from DECODE onward.
REQ-004 SHALL have port funct, input, 6, instruction register bits [5:0].
REQ-005 SHALL have port zero, input, 1, ALU equality flag (a==b).
REQ-006 SHALL have port mem_ready, input, 1, memory access completes this cycle.
REQ-007 SHALL have outputs pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, all 1 bit, datapath controls.
REQ-008 SHALL have outputs alu_src_b (2), pc_source (2), alu_op (3): ALU opcode, 010 add, 011 sub, 100 or, 101 and, 111 slt.
REQ-009 SHALL have outputs pc_en (1) = pc_write | (pc_write_cond & zero), illegal (1), and state (4) for debug.

Function
REQ-010 SHALL be a Moore FSM; all outputs except pc_en, ir_write and pc_write decode from the state register only; any signal not listed for a state is 0.
REQ-011 SHALL use the state encoding RESET=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, ADDI_EX=11, ADDI_WB=12, ILLEGAL=13; codes 14-15 SHALL go to FETCH.
REQ-012 RESET: all outputs 0, alu_op=000; next state FETCH unconditionally.
REQ-013 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=010, pc_source=00; ir_write=pc_write=mem_ready; stays in FETCH while mem_ready=0, else goes to DECODE.
REQ-014 DECODE: alu_src_a=0, alu_src_b=11, alu_op=010. Next: 0x23/0x2B to MEM_ADDR, 0x00 with funct 0x20/0x22/0x24/0x25/0x2A to R_EXEC, 0x04 to BRANCH, 0x02 to JUMP, 0x08 to ADDI_EX (REQ-026), else ILLEGAL.
REQ-015 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=010; next MEM_READ if opcode 0x23, else MEM_WRITE.
REQ-016 MEM_READ: mem_read=1, iord=1; stays while mem_ready=0; then MEM_WB.
REQ-017 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-018 MEM_WRITE: mem_write=1, iord=1; stays while mem_ready=0; then FETCH.
REQ-019 R_EXEC: alu_src_a=1, alu_src_b=00; alu_op from funct: 0x20->010, 0x22->011, 0x24->101, 0x25->100, 0x2A->111; next R_WB.
REQ-020 R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; next FETCH.
REQ-021 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=011, pc_write_cond=1, pc_source=01; next FETCH.
REQ-022 JUMP: pc_write=1, pc_source=10; next FETCH.
REQ-023 ILLEGAL: illegal=1 for exactly one cycle; next FETCH; no register or memory write.
REQ-024 Instruction latency SHALL be, with mem_ready=1 throughout: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles, each starting in FETCH.

Reset
REQ-025 rst=1 at a clock edge SHALL force state to RESET from any state, including mid-wait on mem_ready; rst overrides all transitions; the first FETCH SHALL occur 2 edges after the edge on which rst is sampled 0.

Configuration
REQ-026 Macro MC_CTRL_ADDI_EN: when defined, opcode 0x08 SHALL go to ADDI_EX (alu_src_a=1, alu_src_b=10, alu_op=010), then ADDI_WB (reg_write=1, reg_dst=0, mem_to_reg=0), then FETCH. When undefined, 0x08 SHALL go to ILLEGAL, and states 11-12 SHALL go to FETCH.

Verification
REQ-027 rst high 2 cycles, then low -> state 0, all outputs 0; FETCH on 2nd edge after rst low.
REQ-028 opcode=0x00, funct=0x2A, mem_ready=1 -> states 1,2,7,8,1; alu_op=111 in R_EXEC; reg_write=1, reg_dst=1 in R_WB.
REQ-029 lw (0x23), mem_ready low 3 cycles in MEM_READ -> MEM_READ held 4 cycles with iord=1; MEM_WB asserts mem_to_reg=1.
REQ-030 beq (0x04) with zero=1 then zero=0 -> pc_en=1 and pc_en=0 in BRANCH respectively; pc_source=01 both cases.
REQ-031 opcode=0x3F -> ILLEGAL one cycle, illegal=1, then FETCH; opcode 0x08 -> ADDI path with MC_CTRL_ADDI_EN, ILLEGAL without.
REQ-032 rst asserted while in MEM_WRITE with mem_ready=0 -> RESET next edge, mem_write=0.
